// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. One addition is accepted from IDLE on a start pulse. The
// operands are then added one bit per clock, LSB first, over WIDTH RUN cycles.
// A one-cycle DONE state follows, and the FSM returns to IDLE. The result stays
// on sum/cout until the next accepted start.
//
// Parameters
//   WIDTH  operand width in bits, legal range 2..32 (default 8)
//
// Ports
//   clk    single clock; all state changes on its rising edge
//   rst    synchronous, active-high reset; takes priority over start
//   start  request to begin one addition (accepted only in IDLE)
//   a, b   augend / addend, sampled only on the accepting edge
//   busy   high while bits are being processed (RUN)
//   done   one-cycle pulse marking sum/cout valid (DONE)
//   sum    a + b mod 2^WIDTH
//   cout   carry out of bit WIDTH-1
//   ovf    (only with SERIAL_ADDER_OVF_EN defined) signed two's-complement
//          overflow, i.e. carry into the MSB xor carry out of the MSB
//
// Build options
//   SERIAL_ADDER_OVF_EN  when defined, adds the ovf output and its register
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // The counter can hold WIDTH itself, so it never wraps during an operation.
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_bit;
  logic             last_bit;

  // Full adder on the current LSBs and the carry FF.
  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    c_bit    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    last_bit = (cnt == LAST);
  end

  // Next-state logic. busy and done come straight from the state, so they are
  // never high together.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath. Sum bits enter from the MSB side. After WIDTH shifts, bit 0 of
  // the operands therefore ends up at sum[0]. Outside RUN, nothing moves, so
  // the last result holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum   <= {s_bit, sum[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_bit;
          cnt   <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // After the final RUN cycle, the carry FF holds the carry out of the MSB.
  assign cout = carry;

`ifdef SERIAL_ADDER_OVF_EN
  // Overflow is captured on the MSB cycle. At that point, the carry FF is the
  // carry into the MSB and c_bit is the carry out of it. It is cleared on
  // accept, like the carry FF, so it tracks cout's timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      ovf <= 1'b0;
    end else if (state == RUN && last_bit) begin
      ovf <= carry ^ c_bit;
    end
  end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH = 8). A behavioural model
// predicts busy/done timing from the number of edges since the accepting edge.
// It predicts the result with plain integer addition. A negedge compare
// process checks the DUT against the model every cycle. Directed cases pin the
// model with literal values, followed by a 1000-operation random regression.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Shared comparison routine. Every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model. A phase of -1 means idle. Phase k >= 0 means k edges
  // have passed since the accepting edge. The DUT is busy for phases 0..W-1 and
  // shows done at phase W.
  int           phase     = -1;
  bit           known     = 1'b0;
  bit           res_valid = 1'b0;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] exp_sum   = '0;
  logic         exp_cout  = 1'b0;
  logic         exp_ovf   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      phase     = -1;
      known     = 1'b1;
      exp_sum   = '0;
      exp_cout  = 1'b0;
      exp_ovf   = 1'b0;
      res_valid = 1'b1;
    end else if (known) begin
      if (phase < 0) begin
        if (start) begin
          phase     = 0;
          op_a      = a;
          op_b      = b;
          res_valid = 1'b0;
        end
      end else if (phase < W) begin
        phase++;
        if (phase == W) begin
          {exp_cout, exp_sum} = {1'b0, op_a} + {1'b0, op_b};
          exp_ovf   = (op_a[W-1] == op_b[W-1]) && (exp_sum[W-1] != op_a[W-1]);
          res_valid = 1'b1;
        end
      end else begin
        phase = -1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (known) begin
      checkOutput("busy", {31'b0, busy}, {31'b0, (phase >= 0 && phase < W)});
      checkOutput("done", {31'b0, done}, {31'b0, (phase == W)});
      if (res_valid) begin
        checkOutput("sum", {24'b0, sum}, {24'b0, exp_sum});
        checkOutput("cout", {31'b0, cout}, {31'b0, exp_cout});
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf", {31'b0, ovf}, {31'b0, exp_ovf});
`endif
      end
    end
  end

  // Drives one request at a negedge. Unless hold is set, start is dropped at
  // the following negedge.
  task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit hold);
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Waits for done, with a bounded budget. Returns the number of negedges
  // waited.
  task automatic waitDone(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    checkOutput("done_seen", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int pulses;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_sum", {24'b0, sum}, 32'd0);
    checkOutput("reset_cout", {31'b0, cout}, 32'd0);
    rst = 1'b0;

    // Basic add: done appears W edges after the accepting edge.
    applyStimulus(8'h3C, 8'h5A, 1'b0);
    waitDone(n);
    checkOutput("basic_latency", n, W);
    checkOutput("basic_sum", {24'b0, sum}, 32'h96);
    checkOutput("basic_cout", {31'b0, cout}, 32'd0);

    // Carry out.
    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitDone(n);
    checkOutput("carry_sum", {24'b0, sum}, 32'h00);
    checkOutput("carry_cout", {31'b0, cout}, 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("carry_ovf", {31'b0, ovf}, 32'd0);

    // Signed overflow without carry out.
    applyStimulus(8'h7F, 8'h01, 1'b0);
    waitDone(n);
    checkOutput("ovf_sum", {24'b0, sum}, 32'h80);
    checkOutput("ovf_cout", {31'b0, cout}, 32'd0);
    checkOutput("ovf_flag", {31'b0, ovf}, 32'd1);
`endif

    // Start held high: ignored while busy, re-accepted in the IDLE cycle after
    // done.
    applyStimulus(8'h01, 8'h01, 1'b1);
    waitDone(n);
    checkOutput("hold_latency", n, W + 1);
    checkOutput("hold_sum", {24'b0, sum}, 32'h02);
    a = 8'h03;
    b = 8'h04;
    waitDone(n);
    checkOutput("hold_second_latency", n, W + 2);
    checkOutput("hold_second_sum", {24'b0, sum}, 32'h07);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset on the 4th RUN cycle aborts the operation without a done pulse.
    applyStimulus(8'hA7, 8'h6B, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    checkOutput("abort_sum", {24'b0, sum}, 32'd0);
    checkOutput("abort_cout", {31'b0, cout}, 32'd0);
    pulses = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort_no_done", pulses, 0);

    // Random regression. Spurious start requests with fresh operands are
    // sprinkled in while busy. The model checks that they are ignored and that
    // each result holds until the next accept.
    repeat (1000) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(W'($urandom), W'($urandom), 1'b0);
      n = 0;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
        if (!done) begin
          start = ($urandom_range(0, 3) == 0);
          a     = W'($urandom);
          b     = W'($urandom);
        end else begin
          start = 1'b0;
        end
      end
      checkOutput("rand_done_seen", {31'b0, done}, 32'd1);
      start = 1'b0;
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
